dram_readout_uart_framer: RTL and testbench

- Parametrised successor to the readout-dump logic in the DRAM test tops.
- Snapshots NUM_CH readout words of DATA_W bits when a read completes. Emits them as one framed byte stream into the existing uart_send instance.
- Frame layout: header byte, per-channel payload plus separator, XOR checksum byte.
- Selectable raw-binary or uppercase hex-ASCII payload; proper busy handshake with timeout; overrun and frame-count status.

---
 rtl/dram_readout_uart_framer_if.sv | 26 ++
 rtl/dram_readout_uart_framer.sv | 158 +++++++++++++++
 tb/tb_dram_readout_uart_framer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dram_readout_uart_framer_if.sv
// Framer-side bundle: start/snapshot inputs, uart_send handshake and frame status.
// master = framer, slave = whatever drives start/data and models uart_send.
interface dram_readout_uart_framer_if #(
  parameter int NUM_CH = 16,
  parameter int DATA_W = 8
);
  logic                       start;
  logic                       hex_mode;
  logic [NUM_CH*DATA_W-1:0]   data_flat;
  logic                       uart_busy;
  logic                       uart_en;
  logic [7:0]                 uart_din;
  logic                       busy;
  logic                       done;
  logic                       overrun;
  logic [7:0]                 frame_cnt;

  modport master (
    input  start, hex_mode, data_flat, uart_busy,
    output uart_en, uart_din, busy, done, overrun, frame_cnt
  );
  modport slave (
    output start, hex_mode, data_flat, uart_busy,
    input  uart_en, uart_din, busy, done, overrun, frame_cnt
  );
endinterface

// File: rtl/dram_readout_uart_framer.sv
// Snapshots NUM_CH readout words on a start edge and streams them to uart_send
// as header, per-channel payload + separator, then XOR checksum.
module dram_readout_uart_framer #(
  parameter int          NUM_CH   = 16,
  parameter int          DATA_W   = 8,
  parameter logic [7:0]  HDR_BYTE = 8'hA5,
  parameter logic [7:0]  SEP_BYTE = 8'h0A,
  parameter int          BUSY_TO  = 16
) (
  input  logic                        clk_100m,
  input  logic                        rst,
  dram_readout_uart_framer_if.master  bus
);
  localparam int RAW_N = (DATA_W + 7) / 8;
  localparam int HEX_N = (DATA_W + 3) / 4;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int J_W   = 3;
  localparam int TO_W  = $clog2(BUSY_TO + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SEND, S_WAIT_HI, S_WAIT_LO, S_FIN} state_t;
  typedef enum logic [1:0] {G_HDR, G_PAY, G_SEP, G_CSUM} seg_t;

  state_t                         r_state;
  seg_t                           r_seg;
  logic [CH_W-1:0]                r_ch;
  logic [J_W-1:0]                 r_j;
  logic [TO_W-1:0]                r_to;
  logic [NUM_CH-1:0][DATA_W-1:0]  r_snap;
  logic                           r_hex;
  logic [7:0]                     r_csum, r_byte;
  logic                           r_start_s, r_start_q;
  logic                           r_uart_en, r_busy, r_done, r_overrun;
  logic [7:0]                     r_uart_din, r_frame_cnt;

  logic                           w_edge, w_last;
  logic [31:0]                    w_word;
  logic [3:0]                     w_nib;
  logic [7:0]                     w_byte;
  logic [J_W-1:0]                 w_last_j, w_nj;
  logic [CH_W-1:0]                w_nch;
  seg_t                           w_nseg;

  assign w_edge   = r_start_s & ~r_start_q;
  assign w_last   = (r_seg == G_CSUM);
  assign w_word   = 32'(r_snap[r_ch]);
  assign w_last_j = J_W'(r_hex ? HEX_N - 1 : RAW_N - 1);

  // Payload bytes/characters are taken most-significant first from the zero-padded word
  always_comb begin
    w_nib  = 4'(w_word >> (4 * (HEX_N - 1 - int'(r_j))));
    w_byte = HDR_BYTE;
    case (r_seg)
      G_HDR:   w_byte = HDR_BYTE;
      G_PAY:   if (r_hex) w_byte = (w_nib < 4'd10) ? 8'h30 + {4'h0, w_nib} : 8'h37 + {4'h0, w_nib};
               else       w_byte = 8'(w_word >> (8 * (RAW_N - 1 - int'(r_j))));
      G_SEP:   w_byte = SEP_BYTE;
      G_CSUM:  w_byte = r_csum;
      default: w_byte = HDR_BYTE;
    endcase
  end

  always_comb begin
    w_nseg = r_seg;
    w_nch  = r_ch;
    w_nj   = r_j;
    case (r_seg)
      G_HDR: begin w_nseg = G_PAY; w_nch = '0; w_nj = '0; end
      G_PAY: if (r_j == w_last_j) w_nseg = G_SEP;
             else                 w_nj   = r_j + J_W'(1);
      G_SEP: if (r_ch == CH_W'(NUM_CH - 1)) w_nseg = G_CSUM;
             else begin w_nseg = G_PAY; w_nch = r_ch + CH_W'(1); w_nj = '0; end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_seg       <= G_HDR;
      r_ch        <= '0;
      r_j         <= '0;
      r_to        <= '0;
      r_snap      <= '0;
      r_hex       <= 1'b0;
      r_csum      <= '0;
      r_byte      <= '0;
      r_start_s   <= 1'b0;
      r_start_q   <= 1'b0;
      r_uart_en   <= 1'b0;
      r_uart_din  <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_cnt <= '0;
    end else begin
      r_start_s <= bus.start;
      r_start_q <= r_start_s;
      r_uart_en <= 1'b0;
      r_done    <= 1'b0;
      // Any edge outside IDLE (FIN included) is an overrun and never starts a frame
      if (w_edge && r_state != S_IDLE) r_overrun <= 1'b1;
      case (r_state)
        S_IDLE: if (w_edge) begin
          r_snap    <= bus.data_flat;
          r_hex     <= bus.hex_mode;
          r_overrun <= 1'b0;
          r_csum    <= '0;
          r_busy    <= 1'b1;
          r_seg     <= G_HDR;
          r_ch      <= '0;
          r_j       <= '0;
          r_state   <= S_LOAD;
        end
        S_LOAD: begin
          r_byte  <= w_byte;
          r_state <= S_SEND;
        end
        S_SEND: begin
          r_uart_en  <= 1'b1;
          r_uart_din <= r_byte;
          r_csum     <= r_csum ^ r_byte;
          r_to       <= '0;
          r_state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (bus.uart_busy) r_state <= S_WAIT_LO;
          else if (r_to == TO_W'(BUSY_TO - 1)) begin
            // uart_send never acknowledged; treat the byte as sent
            if (w_last) r_state <= S_FIN;
            else begin
              r_seg <= w_nseg; r_ch <= w_nch; r_j <= w_nj; r_state <= S_LOAD;
            end
          end else r_to <= r_to + TO_W'(1);
        end
        S_WAIT_LO: if (!bus.uart_busy) begin
          if (w_last) r_state <= S_FIN;
          else begin
            r_seg <= w_nseg; r_ch <= w_nch; r_j <= w_nj; r_state <= S_LOAD;
          end
        end
        S_FIN: begin
          r_done      <= 1'b1;
          r_frame_cnt <= r_frame_cnt + 8'd1;
          r_busy      <= 1'b0;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.uart_en   = r_uart_en;
  assign bus.uart_din  = r_uart_din;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.overrun   = r_overrun;
  assign bus.frame_cnt = r_frame_cnt;
endmodule

// File: tb/tb_dram_readout_uart_framer.sv
// Bench for the readout framer: a 16x8 instance with a randomised uart_send model
// and a 2x12 instance for the hex example and frame counter wrap.
module tb_dram_readout_uart_framer;
  typedef logic [7:0] bq_t[$];

  logic clk = 1'b0;
  logic rst;
  int   n_assert = 0, n_fail = 0;
  bq_t  qa, qb;
  int   done_a = 0, done_b = 0, dbase_a = 0, dbase_b = 0;
  bit   nobusy_a = 1'b0;
  logic [7:0] cnt_a = 8'd0, cnt_b = 8'd0;
  logic [31:0] w [64];
  logic [31:0] w2 [64];

  dram_readout_uart_framer_if #(.NUM_CH(16), .DATA_W(8))  a_if ();
  dram_readout_uart_framer_if #(.NUM_CH(2),  .DATA_W(12)) b_if ();

  dram_readout_uart_framer #(.NUM_CH(16), .DATA_W(8)) u_a (
    .clk_100m(clk), .rst(rst), .bus(a_if.master));
  dram_readout_uart_framer #(.NUM_CH(2), .DATA_W(12)) u_b (
    .clk_100m(clk), .rst(rst), .bus(b_if.master));

  initial forever #5 clk = ~clk;

  // Byte capture and done counting
  initial forever begin
    @(negedge clk);
    if (a_if.uart_en === 1'b1) qa.push_back(a_if.uart_din);
    if (b_if.uart_en === 1'b1) qb.push_back(b_if.uart_din);
    if (a_if.done === 1'b1) done_a++;
    if (b_if.done === 1'b1) done_b++;
  end

  // uart_send models: A with random rise delay/length (or never rising), B fixed
  initial begin
    a_if.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (a_if.uart_en === 1'b1 && !nobusy_a) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        a_if.uart_busy = 1'b1;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        a_if.uart_busy = 1'b0;
      end
    end
  end
  initial begin
    b_if.uart_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (b_if.uart_en === 1'b1) begin
        @(negedge clk); b_if.uart_busy = 1'b1;
        repeat (2) @(negedge clk); b_if.uart_busy = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame built straight from the framing rules
  function automatic bq_t frame_ref(input int nch, input int dw, input bit hex, input logic [31:0] wv [64]);
    bq_t q;
    logic [7:0] cs;
    logic [63:0] v;
    logic [3:0] nib;
    q.push_back(8'hA5);
    for (int ch = 0; ch < nch; ch++) begin
      v = {32'd0, wv[ch]} & ((64'd1 << dw) - 64'd1);
      if (hex) begin
        for (int d = (dw + 3) / 4 - 1; d >= 0; d--) begin
          nib = 4'((v >> (4 * d)) & 64'hF);
          q.push_back(nib < 10 ? 8'h30 + 8'(nib) : 8'h41 + 8'(nib) - 8'd10);
        end
      end else begin
        for (int d = (dw + 7) / 8 - 1; d >= 0; d--) q.push_back(8'((v >> (8 * d)) & 64'hFF));
      end
      q.push_back(8'h0A);
    end
    cs = 8'h00;
    foreach (q[i]) cs ^= q[i];
    q.push_back(cs);
    return q;
  endfunction

  task automatic kick(input bit sel, input logic [31:0] wv [64], input bit hex);
    int lat;
    bit seen;
    @(negedge clk);
    if (sel) begin
      for (int k = 0; k < 2; k++) b_if.data_flat[k*12 +: 12] = wv[k][11:0];
      b_if.hex_mode = hex; qb.delete(); dbase_b = done_b; b_if.start = 1'b1;
    end else begin
      for (int k = 0; k < 16; k++) a_if.data_flat[k*8 +: 8] = wv[k][7:0];
      a_if.hex_mode = hex; qa.delete(); dbase_a = done_a; a_if.start = 1'b1;
    end
    lat = 0; seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? (b_if.uart_en === 1'b1) : (a_if.uart_en === 1'b1);
    end
    check(sel ? "latency_b" : "latency_a", lat, 4);
    if (sel) b_if.start = 1'b0; else a_if.start = 1'b0;
  endtask

  task automatic cmp(input bit sel, input bq_t exp, input string tag);
    bq_t got;
    got = sel ? qb : qa;
    check({tag, "_len"}, got.size(), exp.size());
    for (int i = 0; i < exp.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), (i < got.size()) ? got[i] : 8'hxx, exp[i]);
  endtask

  task automatic finish(input bit sel, input bq_t exp, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20000 && !ok; i++) begin
      @(negedge clk);
      ok = sel ? (done_b != dbase_b) : (done_a != dbase_a);
    end
    check({tag, "_done"}, 32'(ok), 1);
    @(negedge clk);
    cmp(sel, exp, tag);
    if (sel) begin
      cnt_b++;
      check({tag, "_busy"}, b_if.busy, 0);
      check({tag, "_cnt"}, b_if.frame_cnt, cnt_b);
    end else begin
      cnt_a++;
      check({tag, "_busy"}, a_if.busy, 0);
      check({tag, "_cnt"}, a_if.frame_cnt, cnt_a);
    end
  endtask

  task automatic wait_bytes_a(input int n, input string tag);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 5000 && !ok; i++) begin
      @(negedge clk);
      ok = (qa.size() >= n);
    end
    check(tag, 32'(ok), 1);
  endtask

  initial begin
    bq_t lit;
    int  d0, n0;
    rst = 1'b1;
    a_if.start = 1'b0; a_if.hex_mode = 1'b0; a_if.data_flat = '0;
    b_if.start = 1'b0; b_if.hex_mode = 1'b0; b_if.data_flat = '0;
    repeat (3) @(negedge clk);
    check("rst_uart_en", a_if.uart_en, 0);
    check("rst_uart_din", a_if.uart_din, 0);
    check("rst_busy", a_if.busy, 0);
    check("rst_done", a_if.done, 0);
    check("rst_overrun", a_if.overrun, 0);
    check("rst_frame_cnt", a_if.frame_cnt, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // All channels 0x55, raw
    for (int k = 0; k < 64; k++) w[k] = 32'h55;
    kick(0, w, 1'b0);
    finish(0, frame_ref(16, 8, 1'b0, w), "a55");
    check("a55_done_cnt", done_a, 1);

    // Two-channel 12-bit hex example against literal bytes
    w[0] = 32'h3C1; w[1] = 32'hF0A;
    lit = '{8'hA5, 8'h33, 8'h43, 8'h31, 8'h0A, 8'h46, 8'h30, 8'h41, 8'h0A, 8'hD3};
    kick(1, w, 1'b1);
    finish(1, lit, "b_hex");

    // Random frames on both instances, alternating raw/hex
    for (int r = 0; r < 4; r++) begin
      for (int k = 0; k < 64; k++) w[k] = $urandom;
      kick(0, w, r[0]);
      finish(0, frame_ref(16, 8, r[0], w), $sformatf("a_rnd%0d", r));
      kick(1, w, ~r[0]);
      finish(1, frame_ref(2, 12, ~r[0], w), $sformatf("b_rnd%0d", r));
    end

    // Start edge mid-frame with new data: overrun, original snapshot, no second frame
    for (int k = 0; k < 64; k++) begin w[k] = $urandom; w2[k] = $urandom; end
    kick(0, w, 1'b0);
    wait_bytes_a(5, "ovr_progress");
    @(negedge clk);
    for (int k = 0; k < 16; k++) a_if.data_flat[k*8 +: 8] = w2[k][7:0];
    a_if.hex_mode = 1'b1;
    a_if.start = 1'b1;
    repeat (4) @(negedge clk);
    check("ovr_set", a_if.overrun, 1);
    a_if.start = 1'b0;
    finish(0, frame_ref(16, 8, 1'b0, w), "ovr_frame");
    repeat (200) @(negedge clk);
    check("ovr_no_second_len", qa.size(), 34);
    check("ovr_no_second_done", done_a - dbase_a, 1);
    check("ovr_sticky", a_if.overrun, 1);
    kick(0, w2, 1'b1);
    check("ovr_cleared", a_if.overrun, 0);
    finish(0, frame_ref(16, 8, 1'b1, w2), "ovr_next");

    // Start held high for 1000 cycles: exactly one frame
    for (int k = 0; k < 64; k++) w[k] = $urandom;
    @(negedge clk);
    for (int k = 0; k < 16; k++) a_if.data_flat[k*8 +: 8] = w[k][7:0];
    a_if.hex_mode = 1'b0; qa.delete(); dbase_a = done_a;
    a_if.start = 1'b1;
    repeat (1000) @(negedge clk);
    a_if.start = 1'b0;
    repeat (20) @(negedge clk);
    check("hold_done_cnt", done_a - dbase_a, 1);
    cmp(0, frame_ref(16, 8, 1'b0, w), "hold");
    cnt_a++;
    check("hold_cnt", a_if.frame_cnt, cnt_a);

    // uart_busy never rises: every byte advances on the timeout
    nobusy_a = 1'b1;
    for (int k = 0; k < 64; k++) w[k] = $urandom;
    kick(0, w, 1'b1);
    finish(0, frame_ref(16, 8, 1'b1, w), "nobusy");
    nobusy_a = 1'b0;
    repeat (5) @(negedge clk);

    // Reset mid-frame aborts without further strobes
    for (int k = 0; k < 64; k++) w[k] = $urandom;
    kick(0, w, 1'b0);
    wait_bytes_a(5, "rst_progress");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n0 = qa.size(); d0 = done_a;
    repeat (300) @(negedge clk);
    check("midrst_no_strobe", qa.size(), n0);
    check("midrst_no_done", done_a, d0);
    check("midrst_busy", a_if.busy, 0);
    check("midrst_frame_cnt", a_if.frame_cnt, 0);
    cnt_a = 8'd0; cnt_b = 8'd0;

    // 256 frames on the small instance: counter wraps back to zero
    d0 = done_b;
    for (int f = 0; f < 256; f++) begin
      for (int k = 0; k < 2; k++) w[k] = $urandom;
      kick(1, w, f[0]);
      finish(1, frame_ref(2, 12, f[0], w), $sformatf("wrap%0d", f));
    end
    check("wrap_frame_cnt", b_if.frame_cnt, 0);
    check("wrap_done_pulses", done_b - d0, 256);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
